// File: rtl/expr_bist_pkg.sv
// Shared constants, state encoding and LFSR step for the expression BIST.
// Optional golden comparator is enabled by EXPR_BIST_GOLDEN_EN.
package expr_bist_pkg;

  localparam int VEC_W  = 60;
  localparam int RESP_W = 90;

  localparam int LFSR_TAP_HI = 59;
  localparam int LFSR_TAP_LO = 58;

  localparam int MISR_TAP0 = 89;
  localparam int MISR_TAP1 = 88;
  localparam int MISR_TAP2 = 87;
  localparam int MISR_TAP3 = 86;

  localparam logic [RESP_W-1:0] MISR_ONE = 1;
  localparam logic [RESP_W-1:0] MISR_MASK =
      (MISR_ONE << MISR_TAP0) |
      (MISR_ONE << MISR_TAP1) |
      (MISR_ONE << MISR_TAP2) |
      (MISR_ONE << MISR_TAP3);

  localparam logic [VEC_W-1:0] LFSR_ZERO_SUB = 60'h1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [VEC_W-1:0] lfsr_next(
    input logic [VEC_W-1:0] s
  );
    return {s[VEC_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  function automatic logic [VEC_W-1:0] lfsr_seed(
    input logic [VEC_W-1:0] s
  );
    return (s == '0) ? LFSR_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/expr_bist_ctrl_if.sv
// Harness-side bundle of the expression BIST sequencer.
// golden/pass exist only when EXPR_BIST_GOLDEN_EN is defined.
interface expr_bist_ctrl_if;
  import expr_bist_pkg::*;

  logic              start;
  logic              pause;
  logic [VEC_W-1:0]  seed;
  logic [VEC_W-1:0]  stim;
  logic [RESP_W-1:0] resp;
  logic              busy;
  logic              done;
  logic [15:0]       vec_count;
  logic [RESP_W-1:0] signature;
`ifdef EXPR_BIST_GOLDEN_EN
  logic [RESP_W-1:0] golden;
  logic              pass;
`endif

  modport master (
`ifdef EXPR_BIST_GOLDEN_EN
    output golden,
    input  pass,
`endif
    output start,
    output pause,
    output seed,
    output resp,
    input  stim,
    input  busy,
    input  done,
    input  vec_count,
    input  signature
  );

  modport slave (
`ifdef EXPR_BIST_GOLDEN_EN
    input  golden,
    output pass,
`endif
    input  start,
    input  pause,
    input  seed,
    input  resp,
    output stim,
    output busy,
    output done,
    output vec_count,
    output signature
  );

endinterface

// File: rtl/expr_misr.sv
// Multiple-input signature register: shift left, XOR tapped bits into
// bit 0, then XOR in the parallel response word.
module expr_misr
  import expr_bist_pkg::*;
#(
  parameter int           W    = RESP_W,
  parameter logic [W-1:0] TAPS = MISR_MASK
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic fb;

  assign fb = ^(sig & TAPS);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[W-2:0], fb} ^ din;
    end
  end

endmodule

// File: rtl/expr_bist_ctrl.sv
// BIST sequencer: LFSR stimulus, MISR compaction, start/done handshake.
// Define EXPR_BIST_GOLDEN_EN to add the golden signature comparator.
module expr_bist_ctrl
  import expr_bist_pkg::*;
#(
  parameter int NUM_VECTORS = 256
) (
  input logic           clk,
  input logic           reset,
  expr_bist_ctrl_if.slave bus
);

  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  state_t            state;
  logic [VEC_W-1:0]  lfsr;
  logic [15:0]       cnt;
  logic              busy_q;
  logic              done_q;
  logic              fold;
  logic              clr;
  logic [RESP_W-1:0] misr;
`ifdef EXPR_BIST_GOLDEN_EN
  logic              pass_q;
`endif

  // pause gates every state element, so the final fold is simply deferred
  assign fold = (state == RUN) && !bus.pause;
  assign clr  = (state == IDLE) && bus.start;

  expr_misr #(
    .W    (RESP_W),
    .TAPS (MISR_MASK)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (fold),
    .din   (bus.resp),
    .sig   (misr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lfsr   <= LFSR_ZERO_SUB;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef EXPR_BIST_GOLDEN_EN
      pass_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            lfsr   <= lfsr_seed(bus.seed);
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef EXPR_BIST_GOLDEN_EN
            pass_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (!bus.pause) begin
            lfsr <= lfsr_next(lfsr);
            cnt  <= cnt + 16'd1;
            if (cnt == LAST) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
`ifdef EXPR_BIST_GOLDEN_EN
          pass_q <= (misr == bus.golden);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim      = lfsr;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec_count = cnt;
  assign bus.signature = misr;
`ifdef EXPR_BIST_GOLDEN_EN
  assign bus.pass      = pass_q;
`endif

endmodule
